// File: rtl/bram_sched_pkg.sv
// Shared types and encodings for the BRAM access scheduler.
// Holds the FSM states, the last-served encoding and the error-cause bit positions.
package bram_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_F,
    S_BUSY_F,
    S_START_W,
    S_BUSY_W,
    S_FLUSH
  } sched_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam int ERR_FETCH_DONE  = 0;
  localparam int ERR_WRITE_DONE  = 1;
  localparam int ERR_FETCH_EN_W  = 2;
  localparam int ERR_WRITE_WE_F  = 3;
  localparam int ERR_CAUSES      = 4;

endpackage

// File: rtl/sched_tile_counter.sv
// Per-requester tile counter: flags the last tile of a pass and issues a
// registered address-reset pulse to the generator on the following cycle.
module sched_tile_counter #(
  parameter int TILES_PER_PASS = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_wrap,
  output logic o_addr_rst
);

  localparam int CW = $clog2(TILES_PER_PASS + 1);
  localparam logic [CW-1:0] LAST_TILE = CW'(TILES_PER_PASS - 1);

  logic [CW-1:0] r_count;
  logic          r_addrRst;

  assign o_wrap     = i_inc && (r_count == LAST_TILE);
  assign o_addr_rst = r_addrRst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_addrRst <= 1'b0;
    end else begin
      r_addrRst <= o_wrap;
      if (i_clr) begin
        r_count <= '0;
      end else if (i_inc) begin
        r_count <= o_wrap ? '0 : r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_access_scheduler.sv
// Arbitrates one BRAM port between the tile fetch and tile write address
// generators, counting tiles per pass and handling flush between tiles.
module bram_access_scheduler
  import bram_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int TILES_PER_PASS = 8,
  parameter int FAIR_RR        = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fetch_req,
  input  logic                  i_write_req,
  input  logic                  i_flush,
  output logic                  o_fetch_ack,
  output logic                  o_write_ack,
  output logic                  o_fetch_pass_done,
  output logic                  o_write_pass_done,
  output logic                  o_start_fetch,
  output logic                  o_fetch_addr_rst,
  input  logic                  i_fetch_done,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  input  logic                  i_fetch_en,
  output logic                  o_start_write,
  output logic                  o_write_addr_rst,
  input  logic                  i_write_done,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic                  i_write_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic                  o_err,
  output logic                  o_busy
);

  sched_state_t          r_state;
  sched_state_t          w_nextState;
  logic                  r_lastServed;
  logic                  r_flushPending;
  logic                  r_err;
  logic [ERR_CAUSES-1:0] w_errCause;
  logic                  w_flushing;
  logic                  w_fetchCntRst;
  logic                  w_writeCntRst;

  assign w_flushing        = (r_state == S_FLUSH);
  assign o_fetch_ack       = (r_state == S_BUSY_F) && i_fetch_done;
  assign o_write_ack       = (r_state == S_BUSY_W) && i_write_done;
  assign o_start_fetch     = (r_state == S_START_F);
  assign o_start_write     = (r_state == S_START_W);
  assign o_fetch_addr_rst  = w_fetchCntRst || w_flushing;
  assign o_write_addr_rst  = w_writeCntRst || w_flushing;
  assign o_busy            = (r_state != S_IDLE);
  assign o_err             = r_err;

  sched_tile_counter #(.TILES_PER_PASS(TILES_PER_PASS)) u_fetchCounter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (o_fetch_ack),
    .i_clr      (w_flushing),
    .o_wrap     (o_fetch_pass_done),
    .o_addr_rst (w_fetchCntRst)
  );

  sched_tile_counter #(.TILES_PER_PASS(TILES_PER_PASS)) u_writeCounter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (o_write_ack),
    .i_clr      (w_flushing),
    .o_wrap     (o_write_pass_done),
    .o_addr_rst (w_writeCntRst)
  );

  always_comb begin
    w_errCause                 = '0;
    w_errCause[ERR_FETCH_DONE] = i_fetch_done && (r_state != S_BUSY_F);
    w_errCause[ERR_WRITE_DONE] = i_write_done && (r_state != S_BUSY_W);
    w_errCause[ERR_FETCH_EN_W] = i_fetch_en && (r_state == S_BUSY_W);
    w_errCause[ERR_WRITE_WE_F] = i_write_we && (r_state == S_BUSY_F);
  end

  // Requests are only looked at in IDLE; a pending flush always wins there.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_flushPending || i_flush) begin
          w_nextState = S_FLUSH;
        end else if (i_fetch_req && i_write_req) begin
          w_nextState = ((FAIR_RR != 0) && (r_lastServed == REQ_FETCH)) ? S_START_W : S_START_F;
        end else if (i_fetch_req) begin
          w_nextState = S_START_F;
        end else if (i_write_req) begin
          w_nextState = S_START_W;
        end
      end
      S_START_F: w_nextState = S_BUSY_F;
      S_BUSY_F:  if (i_fetch_done) w_nextState = S_IDLE;
      S_START_W: w_nextState = S_BUSY_W;
      S_BUSY_W:  if (i_write_done) w_nextState = S_IDLE;
      S_FLUSH:   w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_bram_addr = '0;
    o_bram_en   = 1'b0;
    o_bram_we   = 1'b0;
    if (r_state == S_BUSY_F) begin
      o_bram_addr = i_fetch_addr;
      o_bram_en   = i_fetch_en;
    end else if (r_state == S_BUSY_W) begin
      o_bram_addr = i_write_addr;
      o_bram_en   = i_write_we;
      o_bram_we   = i_write_we;
    end
  end

  // A flush seen mid-tile is remembered so the tile in flight can finish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_lastServed   <= REQ_WRITE;
      r_flushPending <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (o_fetch_ack) begin
        r_lastServed <= REQ_FETCH;
      end else if (o_write_ack) begin
        r_lastServed <= REQ_WRITE;
      end
      if (w_flushing) begin
        r_flushPending <= 1'b0;
      end else if (i_flush && (r_state != S_IDLE)) begin
        r_flushPending <= 1'b1;
      end
      if (|w_errCause) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
